// File: rtl/memory_stage_pkg.sv
// Shared definitions for the memory stage: FSM state encoding, access-size
// encoding and helpers that derive the lane geometry from the datapath width.
package memory_stage_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT_RD = 2'd2
    } state_e;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    // Number of byte lanes in one bus word.
    function automatic int lanes_f(input int data_w);
        return data_w / 8;
    endfunction

    // Width of the lane index; kept at least 1 so the lane field always exists.
    function automatic int lane_w_f(input int data_w);
        int lanes;
        lanes = data_w / 8;
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for the memory stage.
// Ports:
//   lane, size, load_signed  - access geometry of the instruction in flight
//   wdata_in                 - store data from execute
//   rdata                    - read data returned by the bus
//   be, wdata_out            - byte enables and lane-replicated store data
//   load_data                - extracted and extended load result
module mem_lane_align
    import memory_stage_pkg::*;
#(
    parameter int DATA_W = 24,
    localparam int LANES = lanes_f(DATA_W),
    localparam int LANE_W = lane_w_f(DATA_W)
) (
    input  logic [LANE_W-1:0] lane,
    input  logic              size,
    input  logic              load_signed,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic [DATA_W-1:0] rdata,
    output logic [LANES-1:0]  be,
    output logic [DATA_W-1:0] wdata_out,
    output logic [DATA_W-1:0] load_data
);

    logic [7:0] byte_sel;

    // A byte store drives only its own lane but replicates the byte on every
    // lane, so the memory never needs to shift the data itself.
    always_comb begin
        be        = '0;
        wdata_out = '0;
        if (size == SIZE_WORD) begin
            be        = '1;
            wdata_out = wdata_in;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                be[i]              = (int'(lane) == i);
                wdata_out[8*i +: 8] = wdata_in[7:0];
            end
        end
    end

    // Lane indices beyond the last lane select nothing; such accesses are
    // rejected as misaligned before they ever reach the bus.
    always_comb begin
        byte_sel = '0;
        for (int i = 0; i < LANES; i++) begin
            if (int'(lane) == i) begin
                byte_sel = rdata[8*i +: 8];
            end
        end
        if (size == SIZE_WORD) begin
            load_data = rdata;
        end else begin
            load_data = {{(DATA_W-8){load_signed & byte_sel[7]}}, byte_sel};
        end
    end

endmodule

// File: rtl/memory_stage_bus.sv
// Pipeline memory stage between execute and writeback, talking to a
// req/gnt/rvalid data-memory bus of variable latency.
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_ready + instruction fields     - from execute
//   dmem_req/we/addr/be/wdata, dmem_gnt,
//   dmem_rvalid/rdata                          - data-memory bus
//   out_valid, reg_we_out, reg_to_write_out,
//   data_to_write_out, out_err                 - to writeback
module memory_stage_bus
    import memory_stage_pkg::*;
#(
    parameter int DATA_W  = 24,
    parameter int ADDR_W  = 14,
    parameter int REG_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                mem_we,
    input  logic                mem_re,
    input  logic                size,
    input  logic                load_signed,
    input  logic                mem_to_reg,
    input  logic                reg_we,
    input  logic [REG_W-1:0]    reg_to_write,
    input  logic [DATA_W-1:0]   result,
    input  logic [DATA_W-1:0]   data_to_write,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [ADDR_W-1:0]   dmem_addr,
    output logic [DATA_W/8-1:0] dmem_be,
    output logic [DATA_W-1:0]   dmem_wdata,
    input  logic                dmem_gnt,
    input  logic                dmem_rvalid,
    input  logic [DATA_W-1:0]   dmem_rdata,
    output logic                out_valid,
    output logic                reg_we_out,
    output logic [REG_W-1:0]    reg_to_write_out,
    output logic [DATA_W-1:0]   data_to_write_out,
    output logic                out_err
);

    localparam int LANES  = lanes_f(DATA_W);
    localparam int LANE_W = lane_w_f(DATA_W);
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [LANE_W:0] LANES_V   = (LANE_W+1)'(LANES);
    localparam logic [CNT_W:0]  TIMEOUT_V = (CNT_W+1)'(TIMEOUT);

    state_e state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              h_store_q, h_store_d;
    logic              h_size_q, h_size_d;
    logic              h_signed_q, h_signed_d;
    logic              h_m2r_q, h_m2r_d;
    logic              h_reg_we_q, h_reg_we_d;
    logic [REG_W-1:0]  h_rd_q, h_rd_d;
    logic [DATA_W-1:0] h_result_q, h_result_d;
    logic [DATA_W-1:0] h_wdata_q, h_wdata_d;
    logic              out_valid_q, out_valid_d;
    logic              out_err_q, out_err_d;
    logic              out_reg_we_q, out_reg_we_d;
    logic [REG_W-1:0]  out_rd_q, out_rd_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic              accept, is_mem, misaligned, req_active;
    logic              retire, abort, timeout_hit;
    logic [LANE_W-1:0] lane_in;
    logic [CNT_W:0]    cnt_inc;
    logic [DATA_W-1:0] wb_data, load_data, lane_wdata;
    logic [LANES-1:0]  lane_be;

    // Lane steering works from the held instruction so bus fields stay stable
    // while the request waits for a grant.
    mem_lane_align #(.DATA_W(DATA_W)) u_align (
        .lane        (h_result_q[LANE_W-1:0]),
        .size        (h_size_q),
        .load_signed (h_signed_q),
        .wdata_in    (h_wdata_q),
        .rdata       (dmem_rdata),
        .be          (lane_be),
        .wdata_out   (lane_wdata),
        .load_data   (load_data)
    );

    assign accept      = in_valid & (state_q == IDLE);
    assign is_mem      = mem_we | mem_re;
    assign lane_in     = result[LANE_W-1:0];
    assign misaligned  = ({1'b0, lane_in} >= LANES_V) ||
                         ((size == SIZE_WORD) && (lane_in != '0));
    assign cnt_inc     = {1'b0, cnt_q} + 1'b1;
    // Abort fires in the cycle that would bring the count up to TIMEOUT.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == TIMEOUT_V);
    assign req_active  = (state_q == REQ);

    // Next-state and output-register logic. A grant or read response in the
    // same cycle as the timeout is handled first, so it wins over the abort.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        h_store_d    = h_store_q;
        h_size_d     = h_size_q;
        h_signed_d   = h_signed_q;
        h_m2r_d      = h_m2r_q;
        h_reg_we_d   = h_reg_we_q;
        h_rd_d       = h_rd_q;
        h_result_d   = h_result_q;
        h_wdata_d    = h_wdata_q;
        out_valid_d  = 1'b0;
        out_err_d    = 1'b0;
        out_reg_we_d = out_reg_we_q;
        out_rd_d     = out_rd_q;
        out_data_d   = out_data_q;
        retire       = 1'b0;
        abort        = 1'b0;
        wb_data      = h_m2r_q ? '0 : h_result_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!is_mem || misaligned) begin
                        out_valid_d  = 1'b1;
                        out_err_d    = is_mem & misaligned;
                        out_reg_we_d = reg_we;
                        out_rd_d     = reg_to_write;
                        out_data_d   = mem_to_reg ? '0 : result;
                    end else begin
                        h_store_d  = mem_we;
                        h_size_d   = size;
                        h_signed_d = load_signed;
                        h_m2r_d    = mem_to_reg;
                        h_reg_we_d = reg_we;
                        h_rd_d     = reg_to_write;
                        h_result_d = result;
                        h_wdata_d  = data_to_write;
                        cnt_d      = '0;
                        state_d    = REQ;
                    end
                end
            end
            REQ: begin
                if (dmem_gnt) begin
                    if (h_store_q) begin
                        retire = 1'b1;
                    end else begin
                        cnt_d   = cnt_inc[CNT_W-1:0];
                        state_d = WAIT_RD;
                    end
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_inc[CNT_W-1:0];
                end
            end
            WAIT_RD: begin
                if (dmem_rvalid) begin
                    retire  = 1'b1;
                    wb_data = h_m2r_q ? load_data : h_result_q;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_inc[CNT_W-1:0];
                end
            end
            default: state_d = IDLE;
        endcase

        if (retire || abort) begin
            out_valid_d  = 1'b1;
            out_err_d    = abort;
            out_reg_we_d = h_reg_we_q;
            out_rd_d     = h_rd_q;
            out_data_d   = wb_data;
            cnt_d        = '0;
            state_d      = IDLE;
        end
    end

    // All state, holding and output registers clear asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            h_store_q    <= 1'b0;
            h_size_q     <= 1'b0;
            h_signed_q   <= 1'b0;
            h_m2r_q      <= 1'b0;
            h_reg_we_q   <= 1'b0;
            h_rd_q       <= '0;
            h_result_q   <= '0;
            h_wdata_q    <= '0;
            out_valid_q  <= 1'b0;
            out_err_q    <= 1'b0;
            out_reg_we_q <= 1'b0;
            out_rd_q     <= '0;
            out_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            h_store_q    <= h_store_d;
            h_size_q     <= h_size_d;
            h_signed_q   <= h_signed_d;
            h_m2r_q      <= h_m2r_d;
            h_reg_we_q   <= h_reg_we_d;
            h_rd_q       <= h_rd_d;
            h_result_q   <= h_result_d;
            h_wdata_q    <= h_wdata_d;
            out_valid_q  <= out_valid_d;
            out_err_q    <= out_err_d;
            out_reg_we_q <= out_reg_we_d;
            out_rd_q     <= out_rd_d;
            out_data_q   <= out_data_d;
        end
    end

    // Bus fields are zero outside REQ so an idle or reset stage shows a quiet bus.
    assign in_ready          = (state_q == IDLE);
    assign dmem_req          = req_active;
    assign dmem_we           = req_active & h_store_q;
    assign dmem_addr         = req_active ? h_result_q[ADDR_W+LANE_W-1:LANE_W] : '0;
    assign dmem_be           = req_active ? lane_be : '0;
    assign dmem_wdata        = req_active ? lane_wdata : '0;
    assign out_valid         = out_valid_q;
    assign out_err           = out_err_q;
    assign reg_we_out        = out_reg_we_q & out_valid_q & ~out_err_q;
    assign reg_to_write_out  = out_rd_q;
    assign data_to_write_out = out_data_q;

endmodule
